// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH x DEPTH register pipeline with per-stage valid, stall, flush,
// occupancy count and debug tap. Optional output bypass under DFF_PIPE_BYPASS_EN.
module dff_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int unsigned CW = $clog2(DEPTH + 1),
   localparam int unsigned TW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clock,
   input  logic             reset,
`ifdef DFF_PIPE_BYPASS_EN
   input  logic             bypass,
`endif
   input  logic             en,
   input  logic             flush,
   input  logic             din_valid,
   input  logic [WIDTH-1:0] din,
   output logic             dout_valid,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   input  logic [TW-1:0]    tap_sel,
   output logic [WIDTH-1:0] tap_out,
   output logic             tap_valid
);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;

   // Bubbles shift like real entries; count tracks insert minus drop at the tail.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      count_d = count_q;
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = RESET_VAL;
         end
         valid_d = '0;
         count_d = '0;
      end else if (en) begin
         data_d[0]  = din;
         valid_d[0] = din_valid;
         for (int i = 1; i < DEPTH; i++) begin
            data_d[i]  = data_q[i-1];
            valid_d[i] = valid_q[i-1];
         end
         count_d = count_q + CW'(din_valid) - CW'(valid_q[DEPTH-1]);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= RESET_VAL;
         end
         valid_q <= '0;
         count_q <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   // Out-of-range selects (non power-of-2 DEPTH) fall through to the reset value.
   always_comb begin
      tap_out   = RESET_VAL;
      tap_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (tap_sel == TW'(i)) begin
            tap_out   = data_q[i];
            tap_valid = valid_q[i];
         end
      end
   end

   assign count = count_q;

`ifdef DFF_PIPE_BYPASS_EN
   assign dout       = bypass ? din : data_q[DEPTH-1];
   assign dout_valid = bypass ? din_valid : valid_q[DEPTH-1];
`else
   assign dout       = data_q[DEPTH-1];
   assign dout_valid = valid_q[DEPTH-1];
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe (WIDTH=8, DEPTH=4): vector table, hand sequences and a
// queue-based scoreboard of in-flight valid words with their stage index.
module tb_dff_pipe;
   localparam int DEPTH = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic       flush = 1'b0;
   logic       din_valid = 1'b0;
   logic [7:0] din = 8'h00;
   logic       dout_valid;
   logic [7:0] dout;
   logic [2:0] count;
   logic [1:0] tap_sel = 2'd0;
   logic [7:0] tap_out;
   logic       tap_valid;
`ifdef DFF_PIPE_BYPASS_EN
   logic       bypass = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   // Scoreboard: valid words in flight and the stage each one occupies.
   logic [7:0] exp_q[$];
   int         age_q[$];

   typedef struct {
      logic       e;
      logic       f;
      logic       v;
      logic [7:0] d;
      logic       xdv;
      logic [7:0] xd;
      int         xc;
   } vec_t;
   vec_t tbl[6];

   dff_pipe #(.WIDTH(8), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
      .clock(clock),
      .reset(reset),
`ifdef DFF_PIPE_BYPASS_EN
      .bypass(bypass),
`endif
      .en(en),
      .flush(flush),
      .din_valid(din_valid),
      .din(din),
      .dout_valid(dout_valid),
      .dout(dout),
      .count(count),
      .tap_sel(tap_sel),
      .tap_out(tap_out),
      .tap_valid(tap_valid)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic e, input logic f, input logic v, input logic [7:0] d);
      if (f) begin
         exp_q.delete();
         age_q.delete();
      end else if (e) begin
         foreach (age_q[i]) age_q[i]++;
         if (age_q.size() > 0 && age_q[0] == DEPTH) begin
            void'(exp_q.pop_front());
            void'(age_q.pop_front());
         end
         if (v) begin
            exp_q.push_back(d);
            age_q.push_back(0);
         end
      end
   endtask

   task automatic check_model();
      logic xdv;
      xdv = (age_q.size() > 0) && (age_q[0] == DEPTH - 1);
      chk("dout_valid", 32'(dout_valid), 32'(xdv));
      if (xdv) chk("dout", 32'(dout), 32'(exp_q[0]));
      chk("count", 32'(count), 32'(exp_q.size()));
   endtask

   task automatic check_taps();
      logic       xv;
      logic [7:0] xd;
      for (int s = 0; s < DEPTH; s++) begin
         tap_sel = 2'(s);
         #1;
         xv = 1'b0;
         xd = 8'h00;
         foreach (age_q[i]) begin
            if (age_q[i] == s) begin
               xv = 1'b1;
               xd = exp_q[i];
            end
         end
         chk("tap_valid", 32'(tap_valid), 32'(xv));
         if (xv) chk("tap_out", 32'(tap_out), 32'(xd));
      end
   endtask

   task automatic cyc(input logic e, input logic f, input logic v, input logic [7:0] d);
      en = e;
      flush = f;
      din_valid = v;
      din = d;
      @(posedge clock);
      model_edge(e, f, v, d);
      #1;
      check_model();
   endtask

   initial begin
      logic [7:0] seen_q[$];

      tbl[0] = '{1'b1, 1'b0, 1'b1, 8'h98, 1'b0, 8'h00, 1};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 8'hFC, 1'b0, 8'h00, 2};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 2};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h98, 2};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFC, 1};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 0};

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst_dout", 32'(dout), 32'h00);
      chk("rst_dout_valid", 32'(dout_valid), 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_tap_valid", 32'(tap_valid), 32'h0);
      reset = 1'b0;

      // Latency table
      for (int i = 0; i < 6; i++) begin
         cyc(tbl[i].e, tbl[i].f, tbl[i].v, tbl[i].d);
         chk("tbl_dout_valid", 32'(dout_valid), 32'(tbl[i].xdv));
         chk("tbl_dout", 32'(dout), 32'(tbl[i].xd));
         chk("tbl_count", 32'(count), 32'(tbl[i].xc));
      end

      // Async reset mid-cycle with a full pipeline
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b1, 8'(8'hC0 + i));
      chk("full_count", 32'(count), 32'd4);
      #3;
      reset = 1'b1;
      #1;
      chk("async_rst_dout", 32'(dout), 32'h00);
      chk("async_rst_dout_valid", 32'(dout_valid), 32'h0);
      chk("async_rst_count", 32'(count), 32'h0);
      exp_q.delete();
      age_q.delete();
      check_taps();
      @(posedge clock);
      #1;
      reset = 1'b0;
      check_model();

      // Stall: load three, hold three cycles, resume
      cyc(1'b1, 1'b0, 1'b1, 8'h11);
      cyc(1'b1, 1'b0, 1'b1, 8'h22);
      cyc(1'b1, 1'b0, 1'b1, 8'h33);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 8'hEE);
         chk("stall_count", 32'(count), 32'd3);
         chk("stall_dout_valid", 32'(dout_valid), 32'h0);
         check_taps();
      end
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      chk("resume_dout", 32'(dout), 32'h11);
      chk("resume_dout_valid", 32'(dout_valid), 32'h1);

      // Flush beats en; din not captured
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b1, 8'(8'h50 + i));
      cyc(1'b1, 1'b1, 1'b1, 8'hAA);
      chk("flush_count", 32'(count), 32'h0);
      chk("flush_dout_valid", 32'(dout_valid), 32'h0);
      chk("flush_dout", 32'(dout), 32'h00);
      check_taps();
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00);

      // Steady stream 0x01..0x0A then drain
      for (int i = 1; i <= 14; i++) begin
         if (i <= 10) cyc(1'b1, 1'b0, 1'b1, 8'(i));
         else         cyc(1'b1, 1'b0, 1'b0, 8'h00);
         if (i >= 4 && i <= 10) chk("stream_count", 32'(count), 32'd4);
         if (dout_valid) seen_q.push_back(dout);
      end
      chk("stream_words", 32'(seen_q.size()), 32'd10);
      foreach (seen_q[i]) chk("stream_order", 32'(seen_q[i]), 32'(i + 1));

      // Tap readout
      cyc(1'b1, 1'b0, 1'b1, 8'h10);
      cyc(1'b1, 1'b0, 1'b1, 8'h20);
      cyc(1'b1, 1'b0, 1'b1, 8'h30);
      cyc(1'b1, 1'b0, 1'b1, 8'h40);
      for (int s = 0; s < DEPTH; s++) begin
         tap_sel = 2'(s);
         #1;
         chk("tap_hand_valid", 32'(tap_valid), 32'h1);
         chk("tap_hand_out", 32'(tap_out), 32'(8'h40 - 8'(s) * 8'h10));
      end

      // Random traffic against the scoreboard
      for (int n = 0; n < 300; n++) begin
         cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
         if (n % 10 == 0) check_taps();
      end

`ifdef DFF_PIPE_BYPASS_EN
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      bypass = 1'b1;
      din = 8'h5A;
      din_valid = 1'b1;
      #1;
      chk("bypass_dout", 32'(dout), 32'h5A);
      chk("bypass_dout_valid", 32'(dout_valid), 32'h1);
      bypass = 1'b0;
      #1;
      check_model();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
